trivium_stream: RTL and testbench

- Parametrised successor to the single-shot Trivium encryptor.
- Generates the Trivium keystream W bits per clock instead of a fixed 4096-bit vector.
- Supports a run-time bit length, a valid/ready streaming output with backpressure, partial last words, and abort.
- Sits between the key/IV configuration logic and the XOR/encrypt datapath.

---
 rtl/trivium_stream.sv | 114 +++++++++++
 tb/tb_trivium_stream.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_stream.sv
// trivium_stream: Trivium keystream generator, W bits per cycle, valid/ready output with partial last word and abort.
module trivium_stream #(
  parameter int W = 64,
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [79:0]        key,
  input  logic [79:0]        iv,
  input  logic [LEN_W-1:0]   len,
  input  logic               abort,
  output logic               busy,
  output logic [W-1:0]       ks_data,
  output logic [$clog2(W):0] ks_nbits,
  output logic               ks_valid,
  input  logic               ks_ready,
  output logic               ks_last,
  output logic               done
);
  localparam int IC = 1152 / W;
  localparam int CW = $clog2(IC);
  localparam int NB = $clog2(W) + 1;
  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;
  state_t           state_q, state_d;
  logic [287:0]     s_q, s_d, s_nxt, s_ld;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [W-1:0]     z;
  logic [NB-1:0]    nbits;
  logic             run, last, t1, t2, t3;
  // Trivium bit k (1..288) lives at vector index 288-k.
  function automatic logic sb(input logic [287:0] v, input int k);
    return v[288-k];
  endfunction
  always_comb begin
    s_nxt = s_q;
    z = '0;
    t1 = 1'b0;
    t2 = 1'b0;
    t3 = 1'b0;
    for (int r = 0; r < W; r++) begin
      t1 = sb(s_nxt, 66) ^ sb(s_nxt, 93);
      t2 = sb(s_nxt, 162) ^ sb(s_nxt, 177);
      t3 = sb(s_nxt, 243) ^ sb(s_nxt, 288);
      z[W-1-r] = t1 ^ t2 ^ t3;
      t1 = t1 ^ (sb(s_nxt, 91) & sb(s_nxt, 92)) ^ sb(s_nxt, 171);
      t2 = t2 ^ (sb(s_nxt, 175) & sb(s_nxt, 176)) ^ sb(s_nxt, 264);
      t3 = t3 ^ (sb(s_nxt, 286) & sb(s_nxt, 287)) ^ sb(s_nxt, 69);
      s_nxt = {t3, s_nxt[287:196], t1, s_nxt[194:112], t2, s_nxt[110:1]};
    end
  end
  always_comb begin
    s_ld = '0;
    s_ld[287:208] = key;
    s_ld[194:115] = iv;
    s_ld[2:0] = 3'b111;
  end
  assign run      = state_q == RUN;
  assign nbits    = rem_q >= LEN_W'(W) ? NB'(W) : NB'(rem_q);
  assign last     = rem_q <= LEN_W'(W);
  assign busy     = state_q != IDLE;
  assign ks_valid = run;
  assign ks_last  = run && last;
  assign ks_nbits = run ? nbits : '0;
  assign ks_data  = run ? z & ~({W{1'b1}} >> nbits) : '0;
  assign done     = done_q;
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    if (abort) state_d = IDLE;
    else case (state_q)
      IDLE: if (start) begin
        if (len != '0) begin
          s_d = s_ld;
          rem_d = len;
          cnt_d = '0;
          state_d = INIT;
        end else done_d = 1'b1;
      end
      INIT: begin
        s_d = s_nxt;
        cnt_d = cnt_q + CW'(1);
        state_d = cnt_q == CW'(IC - 1) ? RUN : INIT;
      end
      RUN: if (ks_ready) begin
        s_d = s_nxt;
        rem_d = rem_q - LEN_W'(nbits);
        state_d = last ? IDLE : RUN;
        done_d = last;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_trivium_stream.sv
// tb_trivium_stream: directed checks of the W=64 and W=8 keystream builds against a bit-serial Trivium reference.
module tb_trivium_stream;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, ks_ready = 1'b1;
  logic start8 = 1'b0;
  logic [79:0] key = 80'hFF000102030405060708, iv = '0;
  logic [15:0] len = '0;
  logic        busy, ks_valid, ks_last, done;
  logic [63:0] ks_data;
  logic [6:0]  ks_nbits;
  logic        busy8, ks_valid8, ks_last8, done8;
  logic [7:0]  ks_data8;
  logic [3:0]  ks_nbits8;
  int vectors = 0, miscompares = 0;
  int lat, hs, n;
  logic [63:0] pd;
  logic        pr;
  bit gold [0:4095];

  always #5 clk = ~clk;

  trivium_stream #(.W(64), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .iv(iv), .len(len), .abort(abort),
    .busy(busy), .ks_data(ks_data), .ks_nbits(ks_nbits), .ks_valid(ks_valid),
    .ks_ready(ks_ready), .ks_last(ks_last), .done(done));

  trivium_stream #(.W(8), .LEN_W(16)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .key(key), .iv(iv), .len(len), .abort(1'b0),
    .busy(busy8), .ks_data(ks_data8), .ks_nbits(ks_nbits8), .ks_valid(ks_valid8),
    .ks_ready(1'b1), .ks_last(ks_last8), .done(done8));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int l);
    l = 1;
    while (!ks_valid && l < 2000) begin
      tick();
      l++;
    end
  endtask

  function automatic logic [63:0] gword(input int base, input int wd, input int nb);
    logic [63:0] x = '0;
    for (int i = 0; i < nb; i++) x[wd-1-i] = gold[base+i];
    return x;
  endfunction

  task automatic gen_gold;
    bit s [1:288];
    bit a, b, c;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) s[i] = key[80-i];
    for (int i = 1; i <= 80; i++) s[93+i] = iv[80-i];
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    for (int r = 0; r < 1152 + 4096; r++) begin
      a = s[66] ^ s[93];
      b = s[162] ^ s[177];
      c = s[243] ^ s[288];
      if (r >= 1152) gold[r-1152] = a ^ b ^ c;
      a = a ^ (s[91] & s[92]) ^ s[171];
      b = b ^ (s[175] & s[176]) ^ s[264];
      c = c ^ (s[286] & s[287]) ^ s[69];
      for (int k = 288; k > 178; k--) s[k] = s[k-1];
      s[178] = b;
      for (int k = 177; k > 94; k--) s[k] = s[k-1];
      s[94] = a;
      for (int k = 93; k > 1; k--) s[k] = s[k-1];
      s[1] = c;
    end
  endtask

  initial begin
    gen_gold();
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", ks_valid, 0);
    chk("rst_data", ks_data, 0);
    chk("rst_nbits", ks_nbits, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    tick();
    // Full 4096-bit stream, W=64, ready high, with an ignored start mid-stream.
    len = 16'd4096; start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(lat);
    chk("lat64", lat, 19);
    for (int w = 0; w < 64; w++) begin
      chk("s1_valid", ks_valid, 1);
      chk("s1_nbits", ks_nbits, 64);
      chk("s1_last", ks_last, w == 63);
      chk("s1_data", ks_data, gword(64*w, 64, 64));
      start = (w == 10);
      tick();
      start = 1'b0;
    end
    chk("s1_done", done, 1);
    chk("s1_idle", busy, 0);
    chk("s1_novalid", ks_valid, 0);
    // Back-to-back start in the done cycle.
    len = 16'd64; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_nodone", done, 0);
    wait_valid(lat);
    chk("b2b_lat", lat, 19);
    chk("b2b_last", ks_last, 1);
    chk("b2b_nbits", ks_nbits, 64);
    chk("b2b_data", ks_data, gword(0, 64, 64));
    tick();
    chk("b2b_done", done, 1);
    tick();
    chk("b2b_done_clr", done, 0);
    // W=8 build: latency 145 and identical stream.
    len = 16'd4096; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 1;
    while (!ks_valid8 && lat < 2000) begin
      tick();
      lat++;
    end
    chk("lat8", lat, 145);
    for (int b = 0; b < 512; b++) begin
      chk("w8_data", ks_data8, gword(8*b, 8, 8));
      chk("w8_last", ks_last8, b == 511);
      tick();
    end
    chk("w8_done", done8, 1);
    chk("w8_idle", busy8, 0);
    // len=100 with random backpressure: 64 then 36 bits.
    len = 16'd100; start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(lat);
    chk("p_lat", lat, 19);
    hs = 0; n = 0; pr = 1'b1; pd = '0;
    while (hs < 2 && n < 400) begin
      ks_ready = 1'($urandom_range(0, 1));
      chk("p_valid", ks_valid, 1);
      if (!pr) chk("p_hold", ks_data, pd);
      if (ks_ready) begin
        chk("p_nbits", ks_nbits, hs == 0 ? 64 : 36);
        chk("p_last", ks_last, hs == 1);
        chk("p_data", ks_data, gword(64*hs, 64, hs == 0 ? 64 : 36));
        if (hs == 1) chk("p_low_zero", ks_data[27:0], 0);
        hs++;
      end
      pd = ks_data; pr = ks_ready;
      tick();
      n++;
    end
    ks_ready = 1'b1;
    chk("p_hs", hs, 2);
    chk("p_done", done, 1);
    // Zero-length start.
    len = '0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_valid", ks_valid, 0);
    tick();
    chk("z_done_clr", done, 0);
    // Abort on the third RUN word.
    len = 16'd4096; start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(lat);
    tick(); tick();
    chk("a_word2", ks_data, gword(128, 64, 64));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("a_valid", ks_valid, 0);
    chk("a_busy", busy, 0);
    chk("a_nodone", done, 0);
    tick();
    chk("a_nodone2", done, 0);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("a_start_dropped", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(lat);
    chk("a_relat", lat, 19);
    chk("a_reword0", ks_data, gword(0, 64, 64));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    // Reset pulse mid-INIT.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("r_busy", busy, 0);
    chk("r_valid", ks_valid, 0);
    chk("r_data", ks_data, 0);
    chk("r_nbits", ks_nbits, 0);
    chk("r_done", done, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(lat);
    chk("r_lat", lat, 19);
    chk("r_word0", ks_data, gword(0, 64, 64));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
